// File: rtl/enc_block_position_if.sv
// enc_block_position_if: block handshake and tag bus between the encoder input buffer,
// the block position tagger and the substream packer.
// master = tagger side, slave = surrounding buffer/packer side.
interface enc_block_position_if #(
  parameter int XW = 9,
  parameter int YW = 11
);
  logic          blk_in_valid;
  logic          blk_in_ready;
  logic          blk_out_valid;
  logic          blk_out_ready;
  logic [XW-1:0] blk_pos_x;
  logic [YW-1:0] blk_pos_y;
  logic          out_sof;
  logic          out_sos;
  logic          out_eos;
  logic          out_soc;
  logic          out_eoc;
  logic          out_fls;
  logic          out_eof;

  modport master (
    input  blk_in_valid, blk_out_ready,
    output blk_in_ready, blk_out_valid, blk_pos_x, blk_pos_y,
           out_sof, out_sos, out_eos, out_soc, out_eoc, out_fls, out_eof
  );

  modport slave (
    output blk_in_valid, blk_out_ready,
    input  blk_in_ready, blk_out_valid, blk_pos_x, blk_pos_y,
           out_sof, out_sos, out_eos, out_soc, out_eoc, out_fls, out_eof
  );
endinterface

// File: rtl/enc_block_position.sv
// enc_block_position: encoder-side block position tracker and tagger.
// Walks the blocks of a slice in raster order, tags each accepted block with its
// position and slice/frame flags, and forwards it through one valid/ready register.
module enc_block_position #(
  parameter  int MAX_SLICE_WIDTH  = 2560,
  parameter  int MAX_SLICE_HEIGHT = 2560,
  localparam int SWW = $clog2(MAX_SLICE_WIDTH),
  localparam int SHW = $clog2(MAX_SLICE_HEIGHT),
  localparam int XW  = SWW - 3,
  localparam int YW  = SHW - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [SWW-1:0]       slice_width,
  input  logic [SHW-1:0]       slice_height,
  input  logic [15:0]          frame_height,
  input  logic                 in_sof,
  input  logic                 start_encode,
  enc_block_position_if.master blk,
  output logic                 slice_done,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic [15:0]   line_cnt;
  logic          sticky_sof;
  logic          sticky_eof;

  logic          out_valid;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          o_sof;
  logic          o_sos;
  logic          o_eos;
  logic          o_soc;
  logic          o_eoc;
  logic          o_fls;
  logic          o_eof;

  logic          in_ready;
  logic          accept;

  logic [XW:0]   nx_m1;
  logic [YW:0]   ny_m1;
  logic          x_last;
  logic          y_last;
  logic          f_sos;
  logic          f_eos;
  logic          f_soc;
  logic          f_eoc;
  logic          f_fls;
  logic          f_sof;
  logic          f_eof;
  logic [15:0]   line_base;
  logic [16:0]   line_sum;
  logic [15:0]   line_new;

  // The low bits of the dimensions are always zero (multiples of 8 / 2).
  logic          unused_dim_bits;
  assign unused_dim_bits = ^{slice_width[2:0], slice_height[0]};

  // Last column/row indices, one bit wider so a zero dimension never matches.
  assign nx_m1 = {1'b0, slice_width[SWW-1:3]}  - {{XW{1'b0}}, 1'b1};
  assign ny_m1 = {1'b0, slice_height[SHW-1:1]} - {{YW{1'b0}}, 1'b1};

  assign x_last = ({1'b0, cnt_x} == nx_m1);
  assign y_last = ({1'b0, cnt_y} == ny_m1);

  assign f_sos = (cnt_x == '0) && (cnt_y == '0);
  assign f_eos = x_last && y_last;
  assign f_soc = (cnt_x == '0);
  assign f_eoc = x_last;
  assign f_fls = (cnt_y == '0);

  // A start-of-frame marker arriving together with the first block still counts.
  assign f_sof = f_sos && (sticky_sof || in_sof);

  // Frame start restarts the line count, so its first completed row counts as 2 lines.
  assign line_base = f_sof ? 16'd0 : line_cnt;
  assign line_sum  = {1'b0, line_base} + 17'd2;
  assign line_new  = line_sum[16] ? 16'hFFFF : line_sum[15:0];

  // Once the frame bottom is reached, every later block of the frame stays marked.
  assign f_eof = (sticky_eof && !f_sof) ||
                 (f_eoc && (line_sum >= {1'b0, frame_height}));

  assign accept = blk.blk_in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: flush beats start_encode, which restarts from any state.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (start_encode) begin
      state_nxt = ACTIVE;
    end else begin
      case (state)
        ACTIVE: if (accept && f_eos) state_nxt = DRAIN;
        DRAIN:  if (!out_valid || blk.blk_out_ready) state_nxt = DONE;
        DONE:   state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // FSM outputs: input handshake and the end-of-slice/frame pulses.
  always_comb begin
    in_ready   = 1'b0;
    slice_done = 1'b0;
    frame_done = 1'b0;
    if (state == ACTIVE && !start_encode && !flush && (!out_valid || blk.blk_out_ready)) begin
      in_ready = 1'b1;
    end
    if (state == DONE) begin
      slice_done = 1'b1;
      frame_done = o_eof;
    end
  end

  // Position counters, frame tracking and the tagged output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_x      <= '0;
      cnt_y      <= '0;
      line_cnt   <= '0;
      sticky_sof <= 1'b0;
      sticky_eof <= 1'b0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      o_sof      <= 1'b0;
      o_sos      <= 1'b0;
      o_eos      <= 1'b0;
      o_soc      <= 1'b0;
      o_eoc      <= 1'b0;
      o_fls      <= 1'b0;
      o_eof      <= 1'b0;
    end else if (flush) begin
      cnt_x      <= '0;
      cnt_y      <= '0;
      line_cnt   <= '0;
      sticky_sof <= 1'b0;
      sticky_eof <= 1'b0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      o_sof      <= 1'b0;
      o_sos      <= 1'b0;
      o_eos      <= 1'b0;
      o_soc      <= 1'b0;
      o_eoc      <= 1'b0;
      o_fls      <= 1'b0;
      o_eof      <= 1'b0;
    end else begin
      if (start_encode) begin
        cnt_x <= '0;
        cnt_y <= '0;
      end else if (accept) begin
        if (x_last) begin
          cnt_x <= '0;
          cnt_y <= y_last ? '0 : cnt_y + 1'b1;
        end else begin
          cnt_x <= cnt_x + 1'b1;
        end
      end

      if (accept && f_sos) begin
        sticky_sof <= 1'b0;
      end else if (in_sof) begin
        sticky_sof <= 1'b1;
      end

      if (accept) begin
        line_cnt   <= f_eoc ? line_new : line_base;
        sticky_eof <= f_eof;
        out_valid  <= 1'b1;
        out_x      <= cnt_x;
        out_y      <= cnt_y;
        o_sof      <= f_sof;
        o_sos      <= f_sos;
        o_eos      <= f_eos;
        o_soc      <= f_soc;
        o_eoc      <= f_eoc;
        o_fls      <= f_fls;
        o_eof      <= f_eof;
      end else if (blk.blk_out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

  assign blk.blk_in_ready  = in_ready;
  assign blk.blk_out_valid = out_valid;
  assign blk.blk_pos_x     = out_x;
  assign blk.blk_pos_y     = out_y;
  assign blk.out_sof       = o_sof;
  assign blk.out_sos       = o_sos;
  assign blk.out_eos       = o_eos;
  assign blk.out_soc       = o_soc;
  assign blk.out_eoc       = o_eoc;
  assign blk.out_fls       = o_fls;
  assign blk.out_eof       = o_eof;

endmodule

// File: tb/tb_enc_block_position.sv
// tb_enc_block_position: self-checking bench for the encoder block position tagger.
// Fixed cycle tables for the basic slice and stall cases, hand sequences for
// flush/restart, and randomized slices scored against a raster-order frame model.
module tb_enc_block_position;

  // Tag word: position plus flags {sof,sos,eos,soc,eoc,fls,eof}.
  typedef struct packed {
    logic [8:0]  x;
    logic [10:0] y;
    logic [6:0]  flg;
  } tag_t;

  typedef struct {
    bit       v;
    bit       r;
    bit       st;
    bit       sf;
    bit       e_rdy;
    bit       e_vld;
    int       e_x;
    int       e_y;
    bit [6:0] e_flg;
    bit       e_done;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_sof;
  logic        start_encode;
  logic [11:0] slice_width;
  logic [11:0] slice_height;
  logic [15:0] frame_height;
  logic        slice_done;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  vec_t vecs[$];
  tag_t exp_q[$];
  int   m_lines;
  bit   m_eof;
  bit   m_sof_pending;

  enc_block_position_if #(.XW(9), .YW(11)) bif ();

  enc_block_position dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .slice_width  (slice_width),
    .slice_height (slice_height),
    .frame_height (frame_height),
    .in_sof       (in_sof),
    .start_encode (start_encode),
    .blk          (bif),
    .slice_done   (slice_done),
    .frame_done   (frame_done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic apply_stimulus(input bit v, input bit r, input bit st, input bit sf, input bit fl);
    @(negedge clk);
    bif.blk_in_valid  = v;
    bif.blk_out_ready = r;
    start_encode      = st;
    in_sof            = sf;
    flush             = fl;
    #1;
  endtask

  function automatic tag_t dut_tag();
    tag_t t;
    t.x   = bif.blk_pos_x;
    t.y   = bif.blk_pos_y;
    t.flg = {bif.out_sof, bif.out_sos, bif.out_eos, bif.out_soc,
             bif.out_eoc, bif.out_fls, bif.out_eof};
    return t;
  endfunction

  function automatic void model_reset();
    m_lines       = 0;
    m_eof         = 1'b0;
    m_sof_pending = 1'b0;
  endfunction

  // Expected tags for a whole slice in raster order, updating the frame state.
  function automatic void model_slice(input int nx, input int ny, input int fh);
    tag_t t;
    bit sof, sos, eos, soc, eoc, fls;
    exp_q.delete();
    for (int y = 0; y < ny; y++) begin
      for (int x = 0; x < nx; x++) begin
        sos = (x == 0) && (y == 0);
        eos = (x == nx - 1) && (y == ny - 1);
        soc = (x == 0);
        eoc = (x == nx - 1);
        fls = (y == 0);
        sof = sos && m_sof_pending;
        if (sof) begin
          m_sof_pending = 1'b0;
          m_lines       = 0;
          m_eof         = 1'b0;
        end
        if (eoc) begin
          m_lines = (m_lines + 2 > 65535) ? 65535 : m_lines + 2;
          if (m_lines >= fh) m_eof = 1'b1;
        end
        t.x   = 9'(x);
        t.y   = 11'(y);
        t.flg = {sof, sos, eos, soc, eoc, fls, m_eof};
        exp_q.push_back(t);
      end
    end
  endfunction

  function automatic void add_vec(input bit v, input bit r, input bit st, input bit sf,
                                  input bit rdy, input bit vld, input int x, input int y,
                                  input bit [6:0] flg, input bit done);
    vec_t e;
    e.v = v; e.r = r; e.st = st; e.sf = sf;
    e.e_rdy = rdy; e.e_vld = vld; e.e_x = x; e.e_y = y; e.e_flg = flg; e.e_done = done;
    vecs.push_back(e);
  endfunction

  // Runs one slice with random valid/ready densities and scores every transfer.
  task automatic run_slice(input int nx, input int ny, input int fh, input bit sof,
                           input int pv, input int pr,
                           output tag_t last_tag, output int first_eof, output bit fdone);
    int  total;
    int  acc;
    int  xfer;
    int  last_xfer_cyc;
    bit  done;
    bit  v, r, exp_rdy, exp_vld;
    total         = nx * ny;
    acc           = 0;
    xfer          = 0;
    last_xfer_cyc = -10;
    done          = 1'b0;
    first_eof     = -1;
    fdone         = 1'b0;
    last_tag      = '0;
    if (sof) m_sof_pending = 1'b1;
    model_slice(nx, ny, fh);
    slice_width  = 12'(nx * 8);
    slice_height = 12'(ny * 2);
    frame_height = 16'(fh);
    apply_stimulus(1'b0, 1'b1, 1'b1, sof, 1'b0);
    check_output("start_in_ready", bif.blk_in_ready, 1'b0);
    for (int c = 0; c < 40 * total + 20 && !done; c++) begin
      v = ($urandom_range(99) < pv);
      r = ($urandom_range(99) < pr);
      apply_stimulus(v, r, 1'b0, 1'b0, 1'b0);
      exp_vld = (acc > xfer);
      exp_rdy = (acc < total) && (!exp_vld || r);
      check_output("run_in_ready", bif.blk_in_ready, exp_rdy);
      check_output("run_out_valid", bif.blk_out_valid, exp_vld);
      if (exp_vld && r) begin
        check_output($sformatf("run_tag%0d", xfer), dut_tag(), exp_q[xfer]);
        last_tag = dut_tag();
        if (bif.out_eof && first_eof < 0) first_eof = xfer;
        xfer++;
        last_xfer_cyc = c;
      end
      if (v && exp_rdy) acc++;
      check_output("run_slice_done", slice_done, (xfer == total) && (c == last_xfer_cyc + 1));
      if (slice_done) begin
        check_output("run_frame_done", frame_done, exp_q[total-1].flg[0]);
        fdone = frame_done;
        done  = 1'b1;
      end
    end
    check_output("run_slice_completes", done, 1'b1);
  endtask

  initial begin
    tag_t lt;
    int   fe;
    bit   fd;
    rst                = 1'b1;
    flush              = 1'b0;
    in_sof             = 1'b0;
    start_encode       = 1'b0;
    bif.blk_in_valid   = 1'b0;
    bif.blk_out_ready  = 1'b0;
    slice_width        = 12'd32;
    slice_height       = 12'd4;
    frame_height       = 16'd100;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_in_ready", bif.blk_in_ready, 1'b0);
    check_output("rst_out_valid", bif.blk_out_valid, 1'b0);
    check_output("rst_tag", dut_tag(), '0);
    check_output("rst_slice_done", slice_done, 1'b0);
    check_output("rst_frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 32x4 slice with in_sof and continuous flow, then the same slice with a stall at blk2.
    //      v  r  st sf rdy vld x  y  flags        done
    add_vec(1, 1, 1, 1, 0,  0,  0, 0, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 1,  0,  0, 0, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 1,  1,  0, 0, 7'b1101010, 0);
    add_vec(1, 1, 0, 0, 1,  1,  1, 0, 7'b0000010, 0);
    add_vec(1, 1, 0, 0, 1,  1,  2, 0, 7'b0000010, 0);
    add_vec(1, 1, 0, 0, 1,  1,  3, 0, 7'b0000110, 0);
    add_vec(1, 1, 0, 0, 1,  1,  0, 1, 7'b0001000, 0);
    add_vec(1, 1, 0, 0, 1,  1,  1, 1, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 1,  1,  2, 1, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 0,  1,  3, 1, 7'b0010100, 0);
    add_vec(1, 1, 0, 0, 0,  0,  0, 0, 7'b0000000, 1);
    add_vec(1, 1, 0, 0, 0,  0,  0, 0, 7'b0000000, 0);
    add_vec(1, 1, 1, 0, 0,  0,  0, 0, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 1,  0,  0, 0, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 1,  1,  0, 0, 7'b0101010, 0);
    add_vec(1, 1, 0, 0, 1,  1,  1, 0, 7'b0000010, 0);
    add_vec(1, 0, 0, 0, 0,  1,  2, 0, 7'b0000010, 0);
    add_vec(1, 0, 0, 0, 0,  1,  2, 0, 7'b0000010, 0);
    add_vec(1, 0, 0, 0, 0,  1,  2, 0, 7'b0000010, 0);
    add_vec(1, 1, 0, 0, 1,  1,  2, 0, 7'b0000010, 0);
    add_vec(1, 1, 0, 0, 1,  1,  3, 0, 7'b0000110, 0);
    add_vec(1, 1, 0, 0, 1,  1,  0, 1, 7'b0001000, 0);
    add_vec(1, 1, 0, 0, 1,  1,  1, 1, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 1,  1,  2, 1, 7'b0000000, 0);
    add_vec(1, 1, 0, 0, 0,  1,  3, 1, 7'b0010100, 0);
    add_vec(1, 1, 0, 0, 0,  0,  0, 0, 7'b0000000, 1);
    add_vec(0, 1, 0, 0, 0,  0,  0, 0, 7'b0000000, 0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].v, vecs[i].r, vecs[i].st, vecs[i].sf, 1'b0);
      check_output($sformatf("tbl%0d_in_ready", i), bif.blk_in_ready, vecs[i].e_rdy);
      check_output($sformatf("tbl%0d_out_valid", i), bif.blk_out_valid, vecs[i].e_vld);
      if (vecs[i].e_vld) begin
        check_output($sformatf("tbl%0d_x", i), bif.blk_pos_x, vecs[i].e_x);
        check_output($sformatf("tbl%0d_y", i), bif.blk_pos_y, vecs[i].e_y);
        check_output($sformatf("tbl%0d_flags", i), dut_tag().flg, vecs[i].e_flg);
      end
      check_output($sformatf("tbl%0d_slice_done", i), slice_done, vecs[i].e_done);
      check_output($sformatf("tbl%0d_frame_done", i), frame_done, 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    model_reset();

    // Two 4x2 slices of a 6-line frame: eof first appears on slice 2 row 0 eoc block.
    run_slice(4, 2, 6, 1'b1, 100, 100, lt, fe, fd);
    check_output("eof_s1_first", fe, -1);
    check_output("eof_s1_frame_done", fd, 1'b0);
    run_slice(4, 2, 6, 1'b0, 100, 100, lt, fe, fd);
    check_output("eof_s2_first", fe, 3);
    check_output("eof_s2_frame_done", fd, 1'b1);
    check_output("eof_s2_last_flags", lt.flg, 7'b0010101);

    // Single-block slice carries every position flag.
    run_slice(1, 1, 100, 1'b1, 100, 100, lt, fe, fd);
    check_output("one_blk_flags", lt.flg, 7'b1111110);
    check_output("one_blk_x", lt.x, 0);
    check_output("one_blk_y", lt.y, 0);

    // Flush while block (2,1) sits in the output register.
    slice_width  = 12'd32;
    slice_height = 12'd4;
    frame_height = 16'd100;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("flush_pre_valid", bif.blk_out_valid, 1'b1);
    check_output("flush_pre_x", bif.blk_pos_x, 2);
    check_output("flush_pre_y", bif.blk_pos_y, 1);
    check_output("flush_pre_in_ready", bif.blk_in_ready, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("flush_out_valid", bif.blk_out_valid, 1'b0);
    check_output("flush_in_ready", bif.blk_in_ready, 1'b0);
    check_output("flush_slice_done", slice_done, 1'b0);
    model_reset();
    run_slice(4, 2, 100, 1'b0, 100, 100, lt, fe, fd);

    // Restart mid-slice at X=3 while block (2,0) is held in the output register.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("restart_in_ready", bif.blk_in_ready, 1'b0);
    check_output("restart_hold_tag", dut_tag(), {9'd2, 11'd0, 7'b0000010});
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("restart_pending_tag", dut_tag(), {9'd2, 11'd0, 7'b0000010});
    check_output("restart_accept_ready", bif.blk_in_ready, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("restart_new_valid", bif.blk_out_valid, 1'b1);
    check_output("restart_new_tag", dut_tag(), {9'd0, 11'd0, 7'b0101010});
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    model_reset();

    // Randomized slices sharing one frame state.
    for (int n = 0; n < 25; n++) begin
      run_slice($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(2, 24),
                ($urandom_range(3) == 0), $urandom_range(50, 100), $urandom_range(50, 100),
                lt, fe, fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
